// File: rtl/slt_seq_if.sv
// Request/response bundle for the sequential compare unit.
// A transfer happens on a rising edge where valid && ready; valid holds until then.
interface slt_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic             result;
    logic             eq;
    logic             ovf;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, eq, ovf
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, eq, ovf
    );
endinterface

// File: rtl/slt_seq.sv
// Multi-cycle set-less-than unit: a - b is formed SLICE bits per cycle through a
// registered carry, and the signed/unsigned relations come from the full difference.
module slt_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic        clk,
    input  logic        rst,
    slt_seq_if.slave    bus,
    output logic [1:0]  dbg_state
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic [KW-1:0]      k_q, k_d;
    logic               zero_q, zero_d;
    logic               result_q, result_d;
    logic               eq_q, eq_d;
    logic               ovf_q, ovf_d;

    // The operand registers shift right one slice per RUN cycle, so the slice
    // being processed is always the low SLICE bits and the last slice holds the sign bits.
    logic [SLICE-1:0]   sl_a;
    logic [SLICE-1:0]   sl_b;
    logic [SLICE:0]     sum;
    logic               last;
    logic               n_bit;
    logic               v_bit;
    logic               lt_s;
    logic               lt_u;

    always_comb begin
        sl_a  = a_q[SLICE-1:0];
        sl_b  = b_q[SLICE-1:0];
        sum   = {1'b0, sl_a} + {1'b0, ~sl_b} + {{SLICE{1'b0}}, carry_q};
        last  = (k_q == KW'(NSLICE - 1));
        n_bit = sum[SLICE-1];
        v_bit = (sl_a[SLICE-1] == ~sl_b[SLICE-1]) && (sl_a[SLICE-1] != n_bit);
        lt_s  = n_bit ^ v_bit;
        lt_u  = ~sum[SLICE];
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        k_d      = k_q;
        zero_d   = zero_q;
        result_d = result_q;
        eq_d     = eq_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    carry_d = 1'b1;
                    k_d     = '0;
                    zero_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = sum[SLICE];
                zero_d  = zero_q & (sum[SLICE-1:0] == '0);
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                if (last) begin
                    case (op_q)
                        2'b00:   result_d = lt_s;
                        2'b01:   result_d = lt_u;
                        2'b10:   result_d = ~lt_s;
                        default: result_d = ~lt_u;
                    endcase
                    eq_d    = zero_q & (sum[SLICE-1:0] == '0);
                    ovf_d   = v_bit;
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            k_q      <= '0;
            zero_q   <= 1'b0;
            result_q <= 1'b0;
            eq_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            k_q      <= k_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            eq_q     <= eq_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.eq        = eq_q;
    assign bus.ovf       = ovf_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_slt_seq.sv
// Directed bench for slt_seq: three instances (SLICE 8, 4, 32) share operands and
// reset; sel chooses which one a step talks to.
module tb_slt_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  iv;
    logic [31:0] ta;
    logic [31:0] tb_v;
    logic [1:0]  top;
    logic        ordy;
    logic [1:0]  st8, st4, st32;
    int          checks = 0;
    int          errors = 0;
    int          sel = 0;

    logic        m_in_ready, m_out_valid, m_result, m_eq, m_ovf;
    logic [1:0]  m_state;

    always #5 clk = ~clk;

    slt_seq_if #(.WIDTH(32)) if8 ();
    slt_seq_if #(.WIDTH(32)) if4 ();
    slt_seq_if #(.WIDTH(32)) if32 ();

    assign if8.in_valid   = iv[0];
    assign if8.a          = ta;
    assign if8.b          = tb_v;
    assign if8.op         = top;
    assign if8.out_ready  = ordy;
    assign if4.in_valid   = iv[1];
    assign if4.a          = ta;
    assign if4.b          = tb_v;
    assign if4.op         = top;
    assign if4.out_ready  = ordy;
    assign if32.in_valid  = iv[2];
    assign if32.a         = ta;
    assign if32.b         = tb_v;
    assign if32.op        = top;
    assign if32.out_ready = ordy;

    slt_seq #(.WIDTH(32), .SLICE(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave),  .dbg_state(st8));
    slt_seq #(.WIDTH(32), .SLICE(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4.slave),  .dbg_state(st4));
    slt_seq #(.WIDTH(32), .SLICE(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave), .dbg_state(st32));

    always_comb begin
        case (sel)
            1: begin
                m_in_ready = if4.in_ready; m_out_valid = if4.out_valid; m_result = if4.result;
                m_eq = if4.eq; m_ovf = if4.ovf; m_state = st4;
            end
            2: begin
                m_in_ready = if32.in_ready; m_out_valid = if32.out_valid; m_result = if32.result;
                m_eq = if32.eq; m_ovf = if32.ovf; m_state = st32;
            end
            default: begin
                m_in_ready = if8.in_ready; m_out_valid = if8.out_valid; m_result = if8.result;
                m_eq = if8.eq; m_ovf = if8.ovf; m_state = st8;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input int s, input logic [31:0] av, input logic [31:0] bv, input logic [1:0] opv);
        int n;
        n = 0;
        sel = s;
        #1;
        while (!m_in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_wait", {31'b0, m_in_ready}, 32'd1);
        ta   = av;
        tb_v = bv;
        top  = opv;
        iv[s] = 1'b1;
        @(posedge clk); #1;
        iv = '0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!m_out_valid && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        chk("done_wait", {31'b0, m_out_valid}, 32'd1);
    endtask

    task automatic finish_op(input string tag);
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        chk({tag, "_ovalid_low"}, {31'b0, m_out_valid}, 32'd0);
        chk({tag, "_iready_high"}, {31'b0, m_in_ready}, 32'd1);
    endtask

    task automatic do_op(input int s, input logic [31:0] av, input logic [31:0] bv, input logic [1:0] opv,
                         input logic er, input logic ee, input logic eo, input int elat, input string tag);
        int lat;
        start_op(s, av, bv, opv);
        wait_done(lat);
        chk({tag, "_result"}, {31'b0, m_result}, {31'b0, er});
        chk({tag, "_eq"}, {31'b0, m_eq}, {31'b0, ee});
        chk({tag, "_ovf"}, {31'b0, m_ovf}, {31'b0, eo});
        if (elat > 0) chk({tag, "_latency"}, lat, elat);
        finish_op(tag);
    endtask

    initial begin
        int          lat;
        int          lats[3];
        logic        saw;
        logic [31:0] ra, rb, rd;
        logic [1:0]  rop;
        logic        lts, ltu, er, eo;

        lats[0] = 4; lats[1] = 8; lats[2] = 1;
        rst = 1'b1; iv = '0; ta = '0; tb_v = '0; top = '0; ordy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready_low", {31'b0, m_in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, m_in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, m_out_valid}, 32'd0);
        chk("rst_result", {31'b0, m_result}, 32'd0);
        chk("rst_eq", {31'b0, m_eq}, 32'd0);
        chk("rst_ovf", {31'b0, m_ovf}, 32'd0);
        chk("rst_state", {30'b0, m_state}, 32'd0);

        // Basic signed compare
        do_op(0, 32'd5, 32'd10, 2'b00, 1'b1, 1'b0, 1'b0, 4, "slt_5_10");
        do_op(0, 32'd100, 32'd50, 2'b00, 1'b0, 1'b0, 1'b0, 4, "slt_100_50");

        // Overflow and unsigned
        do_op(0, 32'h7FFFFFFF, 32'h80000000, 2'b00, 1'b0, 1'b0, 1'b1, 4, "ovf_slt");
        do_op(0, 32'h7FFFFFFF, 32'h80000000, 2'b01, 1'b1, 1'b0, 1'b1, 4, "ovf_sltu");
        do_op(0, 32'h7FFFFFFF, 32'h80000000, 2'b10, 1'b1, 1'b0, 1'b1, 4, "ovf_sge");
        do_op(0, 32'h80000000, 32'h7FFFFFFF, 2'b00, 1'b1, 1'b0, 1'b1, 4, "ovf_neg_slt");

        // Equality
        do_op(0, 32'hFFFFFFF1, 32'hFFFFFFF1, 2'b00, 1'b0, 1'b1, 1'b0, 4, "eq_slt");
        do_op(0, 32'hFFFFFFF1, 32'hFFFFFFF1, 2'b11, 1'b1, 1'b1, 1'b0, 4, "eq_sgeu");
        do_op(0, 32'h00000100, 32'h00000000, 2'b00, 1'b0, 1'b0, 1'b0, 4, "neq_slice1");

        // Backpressure with an ignored request pulse in the DONE window
        start_op(0, 32'd5, 32'd10, 2'b00);
        wait_done(lat);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                ta = 32'd50; tb_v = 32'd5; top = 2'b00; iv[0] = 1'b1;
            end
            if (i == 3) iv = '0;
            chk("bp_out_valid", {31'b0, m_out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, m_in_ready}, 32'd0);
            chk("bp_result", {31'b0, m_result}, 32'd1);
            chk("bp_eq", {31'b0, m_eq}, 32'd0);
            chk("bp_ovf", {31'b0, m_ovf}, 32'd0);
            @(posedge clk); #1;
        end
        finish_op("bp");
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_out_valid) saw = 1'b1;
            @(posedge clk); #1;
        end
        chk("bp_no_second_result", {31'b0, saw}, 32'd0);
        chk("bp_idle", {30'b0, m_state}, 32'd0);

        // Reset in the second RUN cycle, after a result=1 op so the clear is visible
        do_op(0, 32'd1, 32'd2, 2'b00, 1'b1, 1'b0, 1'b0, 4, "pre_rst");
        start_op(0, 32'd3, 32'd7, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_state", {30'b0, m_state}, 32'd0);
        chk("mid_rst_out_valid", {31'b0, m_out_valid}, 32'd0);
        chk("mid_rst_result", {31'b0, m_result}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, m_in_ready}, 32'd1);
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_out_valid) saw = 1'b1;
            @(posedge clk); #1;
        end
        chk("mid_rst_no_result", {31'b0, saw}, 32'd0);
        do_op(0, 32'hFFFFFFFB, 32'd0, 2'b00, 1'b1, 1'b0, 1'b0, 4, "post_rst");

        // Parameter sweep
        do_op(1, 32'h80000000, 32'h80000001, 2'b00, 1'b1, 1'b0, 1'b0, 8, "s4_slt");
        do_op(1, 32'h80000000, 32'h80000001, 2'b01, 1'b1, 1'b0, 1'b0, 8, "s4_sltu");
        do_op(2, 32'h80000000, 32'h80000001, 2'b00, 1'b1, 1'b0, 1'b0, 1, "s32_slt");
        do_op(2, 32'h80000000, 32'h80000001, 2'b01, 1'b1, 1'b0, 1'b0, 1, "s32_sltu");

        // Random vectors against a reference compare
        for (int i = 0; i < 1000; i++) begin
            ra  = $urandom;
            rb  = (i % 10 == 0) ? ra : $urandom;
            rop = 2'($urandom_range(0, 3));
            lts = ($signed(ra) < $signed(rb));
            ltu = (ra < rb);
            case (rop)
                2'b00:   er = lts;
                2'b01:   er = ltu;
                2'b10:   er = ~lts;
                default: er = ~ltu;
            endcase
            rd = ra - rb;
            eo = (ra[31] != rb[31]) && (rd[31] != ra[31]);
            do_op(i % 3, ra, rb, rop, er, (ra == rb), eo, lats[i % 3], "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
